mem_stage: RTL



---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_align.sv | 52 +++++
 rtl/mem_stage.sv | 114 +++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: bundle widths, the one-hot
// Mem_mode codes, the FSM state encoding, the execute-stage bundle layout and a
// misalignment helper.
package mem_stage_pkg;

  localparam int unsigned EX_DATA  = 80;
  localparam int unsigned MEM_DATA = 74;

  localparam logic [2:0] ModeByte = 3'b001;
  localparam logic [2:0] ModeHalf = 3'b010;
  localparam logic [2:0] ModeWord = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } ms_state_e;

  // Field order matches the execute-stage packing, MSB first.
  typedef struct packed {
    logic        mem_write;
    logic        mem_read;
    logic        reg_write;
    logic [3:0]  mem_to_reg;
    logic [2:0]  mem_mode;
    logic        mem_read_us;
    logic [31:0] rdata2;
    logic [4:0]  rd;
    logic [31:0] result;
  } ex_bundle_t;

  // Only memory operations can be misaligned; ALU results are free-form.
  function automatic logic is_misaligned(input ex_bundle_t b);
    logic half_bad;
    logic word_bad;
    half_bad = (b.mem_mode == ModeHalf) && b.result[0];
    word_bad = (b.mem_mode == ModeWord) && (b.result[1:0] != 2'b00);
    return (b.mem_read || b.mem_write) && (half_bad || word_bad);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory valid/ready bus between the memory stage (master) and the memory (slave).
//   data_req/data_wr/data_wstrb/data_addr/data_wdata : request, driven by the master
//   data_addr_ok : request accepted; data_data_ok/data_rdata : response
interface mem_stage_if;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic for the memory stage.
//   Store side: byte-enable generation and data replication into the addressed lanes.
//   Load side : lane selection from the read word and sign/zero extension.
// Ports: mode_i (one-hot size), read_us_i (1 = zero extend), addr_i (byte offset),
//   wr_i/load_i (qualify strobes / load data), store_data_i, rdata_i,
//   wstrb_o, wdata_o, load_data_o.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mode_i,
  input  logic        read_us_i,
  input  logic [1:0]  addr_i,
  input  logic        wr_i,
  input  logic        load_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    wstrb_o     = 4'b0000;
    wdata_o     = store_data_i;
    load_data_o = 32'h0;
    byte_lane   = rdata_i[{addr_i, 3'b000} +: 8];
    half_lane   = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (mode_i)
      ModeByte: begin
        wstrb_o     = 4'b0001 << addr_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = read_us_i ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      ModeHalf: begin
        wstrb_o     = 4'b0011 << addr_i;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = read_us_i ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      ModeWord: begin
        wstrb_o     = 4'b1111;
        load_data_o = rdata_i;
      end
      default: ;
    endcase
    if (!wr_i) wstrb_o = 4'b0000;
    if (!load_i) load_data_o = 32'h0;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Registers the execute bundle, runs one load/store at a
// time over the dmem handshake, aligns load data and presents the write-back bundle.
// Ports: clk_i, rst_ni (async active-low); es_valid/ex_data/ms_allowin (upstream);
//   ws_allowin/ms_to_ws_valid/ms_data (downstream); dmem (memory bus master);
//   ms_rd/ms_fd_data/ms_fd_valid (forwarding to decode); ms_misalign (one-cycle pulse).
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                es_valid,
  input  logic [EX_DATA-1:0]  ex_data,
  output logic                ms_allowin,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [MEM_DATA-1:0] ms_data,
  output logic [4:0]          ms_rd,
  output logic [31:0]         ms_fd_data,
  output logic                ms_fd_valid,
  output logic                ms_misalign,
  mem_stage_if.master         dmem
);

  ms_state_e   state_q, state_d;
  logic        ms_valid_q, ms_valid_d;
  ex_bundle_t  ex_q, ex_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;

  ex_bundle_t  ex_in;
  logic        ms_ready_go;
  logic        latch;
  logic        in_mem_op;
  logic        cur_misalign;
  logic        reg_write_eff;
  logic [31:0] load_data;

  assign ex_in        = ex_bundle_t'(ex_data);
  assign ms_ready_go  = (state_q == StIdle) || (state_q == StDone);
  assign ms_allowin   = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign latch        = es_valid && ms_allowin;
  // Misaligned accesses never reach the bus, so they are treated like ALU ops here.
  assign in_mem_op    = (ex_in.mem_read || ex_in.mem_write) && !is_misaligned(ex_in);
  assign cur_misalign = is_misaligned(ex_q);

  always_comb begin
    state_d    = state_q;
    ms_valid_d = ms_valid_q;
    ex_d       = ex_q;
    rdata_d    = rdata_q;
    misalign_d = latch && is_misaligned(ex_in);
    if (ms_allowin) ms_valid_d = es_valid;
    if (latch) ex_d = ex_in;
    unique case (state_q)
      StIdle: if (latch && in_mem_op) state_d = StReq;
      StReq: begin
        if (dmem.data_addr_ok) begin
          state_d = dmem.data_data_ok ? StDone : StWait;
          if (dmem.data_data_ok) rdata_d = dmem.data_rdata;
        end
      end
      StWait: begin
        if (dmem.data_data_ok) begin
          state_d = StDone;
          rdata_d = dmem.data_rdata;
        end
      end
      StDone: if (ms_allowin) state_d = (latch && in_mem_op) ? StReq : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ms_valid_q <= 1'b0;
      ex_q       <= '0;
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ms_valid_q <= ms_valid_d;
      ex_q       <= ex_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  mem_align u_align (
    .mode_i      (ex_q.mem_mode),
    .read_us_i   (ex_q.mem_read_us),
    .addr_i      (ex_q.result[1:0]),
    .wr_i        (ex_q.mem_write),
    .load_i      (ex_q.mem_read && !cur_misalign),
    .store_data_i(ex_q.rdata2),
    .rdata_i     (rdata_q),
    .wstrb_o     (dmem.data_wstrb),
    .wdata_o     (dmem.data_wdata),
    .load_data_o (load_data)
  );

  assign dmem.data_req  = (state_q == StReq);
  assign dmem.data_wr   = ex_q.mem_write;
  assign dmem.data_addr = ex_q.result;

  assign reg_write_eff  = ex_q.reg_write && !cur_misalign;
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign ms_data        = {reg_write_eff, ex_q.mem_to_reg, ex_q.rd, ex_q.result, load_data};
  assign ms_fd_valid    = ms_valid_q && reg_write_eff && (!ex_q.mem_read || state_q == StDone);
  assign ms_rd          = (ms_valid_q && reg_write_eff) ? ex_q.rd : 5'd0;
  assign ms_fd_data     = (ex_q.mem_read && state_q == StDone) ? load_data : ex_q.result;
  assign ms_misalign    = misalign_q;

endmodule
